mc_ctrl: RTL and testbench

- Multi-cycle MIPS control unit. Replaces the single-cycle decoder with an FSM that sequences each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Adds a memory ready handshake, a parametrised-latency multiply/divide wait, and mfhi/mflo.
- Sits between the IR (its `instr` input) and the datapath: PC, NPC, GRF, EXT, ALU, DM, MD unit.

---
 rtl/mc_ctrl_pkg.sv | 72 +++++++
 rtl/mc_ctrl_decode.sv | 38 +++
 rtl/mc_ctrl.sv | 174 +++++++++++++++++
 tb/tb_mc_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS control unit: opcodes, functs,
// FSM state encoding, datapath mux encodings and the decoded-class struct.
package mc_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_MDWAIT = 3'd5
    } state_t;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_OR   = 3'b011;

    localparam logic [2:0] EXT_SIGN = 3'b000;
    localparam logic [2:0] EXT_ZERO = 3'b001;
    localparam logic [2:0] EXT_LUI  = 3'b010;

    localparam logic [2:0] NPC_PC4  = 3'b000;
    localparam logic [2:0] NPC_BEQ  = 3'b001;
    localparam logic [2:0] NPC_JAL  = 3'b010;
    localparam logic [2:0] NPC_JR   = 3'b011;
    localparam logic [2:0] NPC_EXC  = 3'b100;

    localparam logic [2:0] AB_RD2   = 3'b000;
    localparam logic [2:0] AB_EXT   = 3'b001;

    localparam logic [2:0] RW_ALU   = 3'b000;
    localparam logic [2:0] RW_EXT   = 3'b001;
    localparam logic [2:0] RW_DM    = 3'b010;
    localparam logic [2:0] RW_PC4   = 3'b011;
    localparam logic [2:0] RW_HILO  = 3'b100;

    // Exactly one flag is set for any instruction word.
    typedef struct packed {
        logic add;
        logic sub;
        logic jr;
        logic mult;
        logic div;
        logic mfhi;
        logic mflo;
        logic ori;
        logic lw;
        logic sw;
        logic beq;
        logic lui;
        logic jal;
        logic nop;
        logic unk;
    } cls_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational instruction classifier: IR word -> one-hot class flags.
module mc_decode
    import mc_ctrl_pkg::*;
(
    input  logic [31:0] instr_i,
    output cls_t        cls_o
);

    logic [5:0] op;
    logic [5:0] fn;
    logic       rtype;

    assign op    = instr_i[31:26];
    assign fn    = instr_i[5:0];
    assign rtype = (op == OP_RTYPE) && (instr_i != 32'd0);

    always_comb begin
        cls_o      = '0;
        cls_o.nop  = (instr_i == 32'd0);
        cls_o.add  = rtype && (fn == FN_ADD);
        cls_o.sub  = rtype && (fn == FN_SUB);
        cls_o.jr   = rtype && (fn == FN_JR);
        cls_o.mult = rtype && (fn == FN_MULT);
        cls_o.div  = rtype && (fn == FN_DIV);
        cls_o.mfhi = rtype && (fn == FN_MFHI);
        cls_o.mflo = rtype && (fn == FN_MFLO);
        cls_o.ori  = (op == OP_ORI);
        cls_o.lw   = (op == OP_LW);
        cls_o.sw   = (op == OP_SW);
        cls_o.beq  = (op == OP_BEQ);
        cls_o.lui  = (op == OP_LUI);
        cls_o.jal  = (op == OP_JAL);
        cls_o.unk  = ~|{cls_o.nop, cls_o.add, cls_o.sub, cls_o.jr, cls_o.mult,
                        cls_o.div, cls_o.mfhi, cls_o.mflo, cls_o.ori, cls_o.lw,
                        cls_o.sw, cls_o.beq, cls_o.lui, cls_o.jal};
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB/MDWAIT).
// Optional reserved-instruction trap: define MC_CTRL_RI_TRAP_EN to add exc_ri.
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        mem_rdy,
    output logic        ir_we,
    output logic        pc_we,
    output logic [2:0]  ALUop,
    output logic [2:0]  EXTop,
    output logic [2:0]  NPCop,
    output logic [2:0]  ABsel,
    output logic [2:0]  RWsel,
    output logic        GRFWE,
    output logic [4:0]  GRFaddr,
    output logic        DMWN,
    output logic        dm_re,
    output logic        md_start,
    output logic        md_op,
    output logic        hilo_sel,
    output logic        md_busy,
    output logic        retire,
    output logic [2:0]  state
`ifdef MC_CTRL_RI_TRAP_EN
    ,
    output logic        exc_ri
`endif
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    cls_t             c;

    mc_decode u_dec (
        .instr_i (instr),
        .cls_o   (c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state = state_q;

    // Per-instruction datapath controls; the IR is stale during FETCH so they stay idle there.
    always_comb begin
        ALUop    = ALU_ADD;
        EXTop    = EXT_SIGN;
        NPCop    = NPC_PC4;
        ABsel    = AB_RD2;
        RWsel    = RW_ALU;
        GRFaddr  = 5'd0;
        md_op    = 1'b0;
        hilo_sel = 1'b0;
        if (state_q != S_FETCH) begin
            if (c.sub || c.beq)            ALUop = ALU_SUB;
            if (c.ori)                     ALUop = ALU_OR;
            if (c.ori)                     EXTop = EXT_ZERO;
            if (c.lui)                     EXTop = EXT_LUI;
            if (c.ori || c.lw || c.sw)     ABsel = AB_EXT;
            if (c.lui)                     RWsel = RW_EXT;
            if (c.lw)                      RWsel = RW_DM;
            if (c.jal)                     RWsel = RW_PC4;
            if (c.mfhi || c.mflo)          RWsel = RW_HILO;
            if (c.beq)                     NPCop = NPC_BEQ;
            if (c.jal)                     NPCop = NPC_JAL;
            if (c.jr)                      NPCop = NPC_JR;
`ifdef MC_CTRL_RI_TRAP_EN
            if (c.unk)                     NPCop = NPC_EXC;
`endif
            if (c.add || c.sub || c.mfhi || c.mflo) GRFaddr = instr[15:11];
            if (c.lw || c.lui || c.ori)             GRFaddr = instr[20:16];
            if (c.jal)                              GRFaddr = 5'd31;
            md_op    = c.div;
            hilo_sel = c.mflo;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        retire   = 1'b0;
        GRFWE    = 1'b0;
        DMWN     = 1'b0;
        dm_re    = 1'b0;
        md_start = 1'b0;
        md_busy  = 1'b0;
`ifdef MC_CTRL_RI_TRAP_EN
        exc_ri   = 1'b0;
`endif
        case (state_q)
            S_FETCH: begin
                // Gated by rst_n so nothing is latched while reset is held.
                ir_we = mem_rdy && rst_n;
                if (mem_rdy) state_d = S_DECODE;
            end
            S_DECODE: begin
                if (c.nop || c.unk) begin
                    pc_we   = 1'b1;
                    retire  = 1'b1;
                    state_d = S_FETCH;
`ifdef MC_CTRL_RI_TRAP_EN
                    exc_ri  = c.unk;
`endif
                end else if (c.mult || c.div) begin
                    md_start = 1'b1;
                    cnt_d    = c.div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
                    state_d  = S_MDWAIT;
                end else if (c.lui || c.jal || c.mfhi || c.mflo) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (c.lw || c.sw) begin
                    state_d = S_MEM;
                end else if (c.beq || c.jr) begin
                    pc_we   = 1'b1;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                dm_re = c.lw;
                DMWN  = c.sw;
                if (mem_rdy) begin
                    if (c.lw) begin
                        state_d = S_WB;
                    end else begin
                        pc_we   = 1'b1;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_WB: begin
                GRFWE   = 1'b1;
                pc_we   = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_MDWAIT: begin
                md_busy = 1'b1;
                if (cnt_q == '0) begin
                    pc_we   = 1'b1;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: per-instruction vector table checked through a scoreboard
// at retire, plus hand-written reset sequences.
module tb_mc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        mem_rdy;
    logic        ir_we, pc_we, GRFWE, DMWN, dm_re, md_start, md_op, hilo_sel, md_busy, retire;
    logic [2:0]  ALUop, EXTop, NPCop, ABsel, RWsel, state;
    logic [4:0]  GRFaddr;
    logic        exc_s;

    always #5 clk = ~clk;

`ifdef MC_CTRL_RI_TRAP_EN
    logic exc_ri;
    assign exc_s = exc_ri;
    localparam int RI = 1;
`else
    assign exc_s = 1'b0;
    localparam int RI = 0;
`endif

    mc_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .mem_rdy(mem_rdy),
        .ir_we(ir_we), .pc_we(pc_we), .ALUop(ALUop), .EXTop(EXTop),
        .NPCop(NPCop), .ABsel(ABsel), .RWsel(RWsel), .GRFWE(GRFWE),
        .GRFaddr(GRFaddr), .DMWN(DMWN), .dm_re(dm_re), .md_start(md_start),
        .md_op(md_op), .hilo_sel(hilo_sel), .md_busy(md_busy), .retire(retire),
        .state(state)
`ifdef MC_CTRL_RI_TRAP_EN
        , .exc_ri(exc_ri)
`endif
    );

    typedef struct {
        logic [31:0] ins;
        int          fst;    // FETCH cycles with mem_rdy low
        int          mst;    // MEM cycles with mem_rdy low
        int          cyc;
        int          dmre;
        int          dmwn;
        int          busy;
        int          start;
        int          mdop;
        int          grfwe;
        logic [4:0]  addr;
        logic [2:0]  rw;
        logic        hilo;
        logic [2:0]  npc;
        logic [2:0]  alu;
        logic [2:0]  ext;
        logic [2:0]  ab;
        int          exc;
    } vec_t;

    vec_t vecs[16];
    vec_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {1'b0, ir_we, pc_we, ALUop, EXTop, NPCop, ABsel, RWsel, GRFWE, GRFaddr,
                DMWN, dm_re, md_start, md_op, hilo_sel, md_busy, retire, exc_s};
    endfunction

    task automatic run_one(input vec_t v);
        vec_t       e;
        int         cyc = 0, dmre = 0, dmwn = 0, busy = 0, start = 0, mdop = 0;
        int         grfwe = 0, pcwe = 0, irwe = 0, exc = 0, fw = 0, mw = 0;
        logic [4:0] addr = '0;
        logic [2:0] rw = '0, npc = '0, alu = '0, ext = '0, ab = '0;
        logic       hilo = 1'b0;
        logic       got_ir;
        bit         done = 0;
        string      nm;
        sb.push_back(v);
        while (!done && cyc < 100) begin
            @(negedge clk);
            if (state == 3'd0)      begin mem_rdy = (fw >= v.fst); fw++; end
            else if (state == 3'd3) begin mem_rdy = (mw >= v.mst); mw++; end
            else                    mem_rdy = 1'($urandom_range(1));
            #1;
            cyc++;
            got_ir = ir_we;
            irwe  += int'(ir_we);
            pcwe  += int'(pc_we);
            dmre  += int'(dm_re);
            dmwn  += int'(DMWN);
            busy  += int'(md_busy);
            grfwe += int'(GRFWE);
            exc   += int'(exc_s);
            if (md_start) begin start++; mdop = int'(md_op); end
            if (retire) begin
                done = 1;
                addr = GRFaddr; rw = RWsel; hilo = hilo_sel; npc = NPCop;
                alu = ALUop; ext = EXTop; ab = ABsel;
            end
            @(posedge clk);
            #1;
            if (got_ir) instr = v.ins;
        end
        nm = $sformatf("%08h", v.ins);
        if (!done) begin
            n_chk++; n_fail++;
            $display("FAIL %s timeout: no retire in %0d cycles", nm, cyc);
            return;
        end
        e = sb.pop_front();
        chk({nm, " cycles"}, cyc, e.cyc);
        chk({nm, " ir_we"}, irwe, 1);
        chk({nm, " pc_we"}, pcwe, 1);
        chk({nm, " dm_re"}, dmre, e.dmre);
        chk({nm, " DMWN"}, dmwn, e.dmwn);
        chk({nm, " md_busy"}, busy, e.busy);
        chk({nm, " md_start"}, start, e.start);
        chk({nm, " md_op"}, mdop, e.mdop);
        chk({nm, " GRFWE"}, grfwe, e.grfwe);
        chk({nm, " GRFaddr"}, addr, e.addr);
        chk({nm, " RWsel"}, rw, e.rw);
        chk({nm, " hilo_sel"}, hilo, e.hilo);
        chk({nm, " NPCop"}, npc, e.npc);
        chk({nm, " ALUop"}, alu, e.alu);
        chk({nm, " EXTop"}, ext, e.ext);
        chk({nm, " ABsel"}, ab, e.ab);
        chk({nm, " exc_ri"}, exc, e.exc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit hit;
        //          ins           fst mst cyc dmre dmwn busy st mdop we addr    rw    hilo  npc               alu   ext   ab    exc
        vecs[0]  = '{32'h00221820, 0, 0,  4, 0, 0,  0, 0, 0, 1, 5'd3,  3'd0, 1'b0, 3'd0,             3'd0, 3'd0, 3'd0, 0};
        vecs[1]  = '{32'h00223822, 0, 0,  4, 0, 0,  0, 0, 0, 1, 5'd7,  3'd0, 1'b0, 3'd0,             3'd1, 3'd0, 3'd0, 0};
        vecs[2]  = '{32'h342600FF, 0, 0,  4, 0, 0,  0, 0, 0, 1, 5'd6,  3'd0, 1'b0, 3'd0,             3'd3, 3'd1, 3'd1, 0};
        vecs[3]  = '{32'h8C250004, 0, 3,  8, 4, 0,  0, 0, 0, 1, 5'd5,  3'd2, 1'b0, 3'd0,             3'd0, 3'd0, 3'd1, 0};
        vecs[4]  = '{32'hAC250008, 0, 2,  6, 0, 3,  0, 0, 0, 0, 5'd0,  3'd0, 1'b0, 3'd0,             3'd0, 3'd0, 3'd1, 0};
        vecs[5]  = '{32'h10220003, 0, 0,  3, 0, 0,  0, 0, 0, 0, 5'd0,  3'd0, 1'b0, 3'd1,             3'd1, 3'd0, 3'd0, 0};
        vecs[6]  = '{32'h03E00008, 0, 0,  3, 0, 0,  0, 0, 0, 0, 5'd0,  3'd0, 1'b0, 3'd3,             3'd0, 3'd0, 3'd0, 0};
        vecs[7]  = '{32'h3C081234, 0, 0,  3, 0, 0,  0, 0, 0, 1, 5'd8,  3'd1, 1'b0, 3'd0,             3'd0, 3'd2, 3'd0, 0};
        vecs[8]  = '{32'h0C000010, 0, 0,  3, 0, 0,  0, 0, 0, 1, 5'd31, 3'd3, 1'b0, 3'd2,             3'd0, 3'd0, 3'd0, 0};
        vecs[9]  = '{32'h00220018, 0, 0,  7, 0, 0,  5, 1, 0, 0, 5'd0,  3'd0, 1'b0, 3'd0,             3'd0, 3'd0, 3'd0, 0};
        vecs[10] = '{32'h00002012, 0, 0,  3, 0, 0,  0, 0, 0, 1, 5'd4,  3'd4, 1'b1, 3'd0,             3'd0, 3'd0, 3'd0, 0};
        vecs[11] = '{32'h0022001A, 0, 0, 12, 0, 0, 10, 1, 1, 0, 5'd0,  3'd0, 1'b0, 3'd0,             3'd0, 3'd0, 3'd0, 0};
        vecs[12] = '{32'h00004810, 0, 0,  3, 0, 0,  0, 0, 0, 1, 5'd9,  3'd4, 1'b0, 3'd0,             3'd0, 3'd0, 3'd0, 0};
        vecs[13] = '{32'h00000000, 0, 0,  2, 0, 0,  0, 0, 0, 0, 5'd0,  3'd0, 1'b0, 3'd0,             3'd0, 3'd0, 3'd0, 0};
        vecs[14] = '{32'hFC000000, 0, 0,  2, 0, 0,  0, 0, 0, 0, 5'd0,  3'd0, 1'b0, (RI != 0) ? 3'd4 : 3'd0,
                                                                                                     3'd0, 3'd0, 3'd0, RI};
        vecs[15] = '{32'h00221820, 2, 0,  6, 0, 0,  0, 0, 0, 1, 5'd3,  3'd0, 1'b0, 3'd0,             3'd0, 3'd0, 3'd0, 0};

        // Reset state, with mem_rdy high so a stray ir_we would show.
        rst_n = 1'b1; mem_rdy = 1'b1; instr = 32'd0;
        #1 rst_n = 1'b0;
        #2;
        chk("reset state", state, 3'd0);
        chk("reset outputs", all_outs(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1; mem_rdy = 1'b0;

        foreach (vecs[i]) run_one(vecs[i]);
        chk("scoreboard empty", sb.size(), 0);

        // Asynchronous reset while a sw sits in MEM waiting on memory.
        instr = 32'hAC250008;
        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(negedge clk);
            mem_rdy = (state == 3'd0);
            #1;
            if (state == 3'd3) hit = 1;
        end
        chk("sw reached MEM", 32'(hit), 32'd1);
        chk("sw DMWN in MEM", 32'(DMWN), 32'd1);
        #2 mem_rdy = 1'b1; rst_n = 1'b0;
        #1;
        chk("async reset state", state, 3'd0);
        chk("async reset DMWN", 32'(DMWN), 32'd0);
        chk("async reset outputs", all_outs(), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        mem_rdy = 1'b0; rst_n = 1'b1;
        #1;
        chk("post-reset ir_we idle", 32'(ir_we), 32'd0);
        chk("post-reset state", state, 3'd0);
        @(negedge clk);
        mem_rdy = 1'b1;
        #1;
        chk("post-reset ir_we on rdy", 32'(ir_we), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
